// File: rtl/softplus_sq_inverse_pkg.sv
// Shared constants and types for the softplus-squared inverse block.
// Holds the Q8.8 width, the search bracket [X_MIN, X_MAX], the bisection
// iteration count and the controller state enumeration.
package softplus_sq_inverse_pkg;

    localparam int unsigned Q_W   = 16;
    localparam int unsigned ITER  = 12;
    localparam int unsigned CNT_W = 4;

    // Signed Q8.8 search bracket: -8.0 .. +8.0 (4096 LSB steps, 2**ITER).
    localparam logic [Q_W-1:0] X_MIN = 16'hF800;
    localparam logic [Q_W-1:0] X_MAX = 16'h0800;

    typedef enum logic [2:0] {
        StIdle,
        StChkLo,
        StChkHi,
        StSearch,
        StDone
    } state_e;

endpackage

// File: rtl/softplus_sq_eval.sv
// Forward piecewise softplus-squared evaluator (purely combinational).
//   x_i : signed Q8.8 operand
//   f_o : unsigned Q8.8 result, f(x) = sp(x)^2, saturated to 16'hFFFF
// sp(x) is a continuous, non-decreasing piecewise-linear softplus:
//   x <  -8.0        : 16/256 (floor keeps f(-8.0) at 1 LSB)
//   -8.0 <= x < -4.0 : 16/256 + (x + 8.0) / 16
//   -4.0 <= x <  0.0 : 80/256 + (x + 4.0) / 8
//    0.0 <= x        : 208/256 + x - x / 8
module softplus_sq_eval
    import softplus_sq_inverse_pkg::*;
(
    input  logic signed [Q_W-1:0] x_i,
    output logic        [Q_W-1:0] f_o
);

    logic signed [17:0] xe;
    logic        [17:0] off_a;
    logic        [17:0] off_b;
    logic        [17:0] xpos;
    logic        [17:0] sp;
    logic        [35:0] sq;

    always_comb begin
        xe    = {{2{x_i[Q_W-1]}}, x_i};
        // Offsets are only consumed in the segments where they are non-negative.
        off_a = 18'(xe + 18'sd2048);
        off_b = 18'(xe + 18'sd1024);
        xpos  = xe;

        if (xe < -18'sd2048) begin
            sp = 18'd16;
        end else if (xe < -18'sd1024) begin
            sp = 18'd16 + (off_a >> 4);
        end else if (xe < 18'sd0) begin
            sp = 18'd80 + (off_b >> 3);
        end else begin
            sp = 18'd208 + xpos - (xpos >> 3);
        end

        // Q8.8 * Q8.8 -> Q16.16; drop 8 fraction bits back to Q8.8.
        sq = sp * sp;
        if (sq[35:24] != '0) begin
            f_o = '1;
        end else begin
            f_o = sq[23:8];
        end
    end

endmodule

// File: rtl/softplus_sq_inverse.sv
// Inverse of the piecewise softplus-squared function by bisection.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : target handshake; in_ready only while idle
//   y                   : target value, unsigned Q8.8
//   out_valid/out_ready : result handshake; result held until accepted
//   x                   : recovered operand, signed Q8.8
//   sat_lo / sat_hi     : y below f(X_MIN) / at or above f(X_MAX), x clamped
// One shared evaluator is muxed between X_MIN, X_MAX and the bisection
// midpoint depending on state.
module softplus_sq_inverse
    import softplus_sq_inverse_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [Q_W-1:0] y,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [Q_W-1:0] x,
    output logic           sat_lo,
    output logic           sat_hi
);

    state_e           state_q, state_d;
    logic [Q_W-1:0]   y_q, y_d;
    logic [Q_W-1:0]   lo_q, lo_d;
    logic [Q_W-1:0]   hi_q, hi_d;
    logic [Q_W-1:0]   x_q, x_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_lo_q, sat_lo_d;
    logic             sat_hi_q, sat_hi_d;

    logic [Q_W:0]     mid_sum;
    logic [Q_W-1:0]   mid;
    logic [Q_W-1:0]   eval_x;
    logic [Q_W-1:0]   eval_f;
    logic             fits;

    // 17-bit signed sum cannot overflow; dropping bit 0 is the >>> 1.
    always_comb begin
        mid_sum = {lo_q[Q_W-1], lo_q} + {hi_q[Q_W-1], hi_q};
        mid     = Q_W'(mid_sum >> 1);
    end

    always_comb begin
        case (state_q)
            StChkLo: eval_x = X_MIN;
            StChkHi: eval_x = X_MAX;
            default: eval_x = mid;
        endcase
    end

    softplus_sq_eval u_eval (
        .x_i (eval_x),
        .f_o (eval_f)
    );

    assign fits = (eval_f <= y_q);

    always_comb begin
        state_d  = state_q;
        y_d      = y_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        x_d      = x_q;
        cnt_d    = cnt_q;
        sat_lo_d = sat_lo_q;
        sat_hi_d = sat_hi_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    y_d     = y;
                    state_d = StChkLo;
                end
            end
            StChkLo: begin
                if (!fits) begin
                    x_d      = X_MIN;
                    sat_lo_d = 1'b1;
                    sat_hi_d = 1'b0;
                    state_d  = StDone;
                end else begin
                    state_d = StChkHi;
                end
            end
            StChkHi: begin
                if (fits) begin
                    x_d      = X_MAX;
                    sat_lo_d = 1'b0;
                    sat_hi_d = 1'b1;
                    state_d  = StDone;
                end else begin
                    lo_d    = X_MIN;
                    hi_d    = X_MAX;
                    cnt_d   = '0;
                    state_d = StSearch;
                end
            end
            StSearch: begin
                // Invariant: f(lo) <= y < f(hi); ends with hi == lo + 1.
                if (fits) begin
                    lo_d = mid;
                end else begin
                    hi_d = mid;
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(ITER - 1)) begin
                    x_d      = fits ? mid : lo_q;
                    sat_lo_d = 1'b0;
                    sat_hi_d = 1'b0;
                    state_d  = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            y_q      <= '0;
            lo_q     <= '0;
            hi_q     <= '0;
            x_q      <= '0;
            cnt_q    <= '0;
            sat_lo_q <= 1'b0;
            sat_hi_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            y_q      <= y_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            x_q      <= x_d;
            cnt_q    <= cnt_d;
            sat_lo_q <= sat_lo_d;
            sat_hi_q <= sat_hi_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign x         = x_q;
    assign sat_lo    = sat_lo_q;
    assign sat_hi    = sat_hi_q;

endmodule

// File: tb/tb_softplus_sq_inverse.sv
// Bench for softplus_sq_inverse: directed corner cases plus a random sweep
// against a table-driven reference (largest x in the bracket with f(x) <= y).
module tb_softplus_sq_inverse;

    localparam int NUM_RAND = 4000;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] y;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] x;
    logic        sat_lo;
    logic        sat_hi;

    int total = 0;
    int bad   = 0;
    int f_tab [0:4096];

    softplus_sq_inverse dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x         (x),
        .sat_lo    (sat_lo),
        .sat_hi    (sat_hi)
    );

    always #5 clk = ~clk;

    // Golden forward model, real-valued segments in integer LSB units.
    function automatic int f_ref(input int xv);
        int sp;
        int f;
        if (xv < -2048)      sp = 16;
        else if (xv < -1024) sp = 16 + (xv + 2048) / 16;
        else if (xv < 0)     sp = 80 + (xv + 1024) / 8;
        else                 sp = 208 + xv - xv / 8;
        f = (sp * sp) / 256;
        if (f > 65535) f = 65535;
        return f;
    endfunction

    // Reference inverse: saturation tests, then largest x with f(x) <= y.
    task automatic inv_ref(input int yv, output logic [15:0] xe, output logic slo,
                           output logic shi, output int lat);
        int r;
        slo = 1'b0;
        shi = 1'b0;
        if (yv < f_tab[0]) begin
            r = -2048; slo = 1'b1; lat = 2;
        end else if (yv >= f_tab[4096]) begin
            r = 2048; shi = 1'b1; lat = 3;
        end else begin
            r = -2048;
            lat = 15;
            for (int k = 2047; k >= -2048; k--) begin
                if (f_tab[k + 2048] <= yv) begin
                    r = k;
                    break;
                end
            end
        end
        xe = 16'(r);
    endtask

    // Drives one transaction from a negedge with DUT idle; returns at a negedge.
    task automatic do_txn(input logic [15:0] yv, input int hold, output int lat,
                          output logic [15:0] xo, output logic slo, output logic shi);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b1;
        y        = yv;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 60);
        xo  = x;
        slo = sat_lo;
        shi = sat_hi;
        repeat (hold) @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        y         = '0;
        repeat (3) @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (x !== 16'h0000) begin bad++; $display("FAIL reset_x got=%h want=0000", x); end
        total++; if (sat_lo !== 1'b0) begin bad++; $display("FAIL reset_sat_lo got=%b want=0", sat_lo); end
        total++; if (sat_hi !== 1'b0) begin bad++; $display("FAIL reset_sat_hi got=%b want=0", sat_hi); end
        rst = 1'b0;
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_directed();
        logic [15:0] yv [3];
        logic [15:0] xo, xe;
        logic        slo, shi, elo, ehi;
        int          lat, elat;
        yv[0] = 16'h0000;
        yv[1] = 16'hFFFF;
        yv[2] = 16'(f_ref(256));
        for (int i = 0; i < 3; i++) begin
            do_txn(yv[i], 0, lat, xo, slo, shi);
            inv_ref(int'(yv[i]), xe, elo, ehi, elat);
            total++; if (lat !== elat) begin bad++; $display("FAIL dir%0d_latency got=%0d want=%0d", i, lat, elat); end
            total++; if (xo !== xe) begin bad++; $display("FAIL dir%0d_x got=%h want=%h", i, xo, xe); end
            total++; if (slo !== elo) begin bad++; $display("FAIL dir%0d_sat_lo got=%b want=%b", i, slo, elo); end
            total++; if (shi !== ehi) begin bad++; $display("FAIL dir%0d_sat_hi got=%b want=%b", i, shi, ehi); end
        end
        // Independent spot values of the forward model's inverse.
        do_txn(16'h0000, 0, lat, xo, slo, shi);
        total++; if (xo !== 16'hF800) begin bad++; $display("FAIL const_sat_lo_x got=%h want=f800", xo); end
        do_txn(16'hFFFF, 0, lat, xo, slo, shi);
        total++; if (xo !== 16'h0800) begin bad++; $display("FAIL const_sat_hi_x got=%h want=0800", xo); end
        do_txn(16'd729, 0, lat, xo, slo, shi);
        total++; if (xo !== 16'h0100) begin bad++; $display("FAIL const_mid_x got=%h want=0100", xo); end
    endtask

    task automatic test_backpressure();
        logic [15:0] ya, yb, xa, xb, xo;
        logic        la, ha, lb, hb;
        int          lat, elat, guard;
        ya = 16'd3000;
        yb = 16'd100;
        inv_ref(int'(ya), xa, la, ha, elat);
        in_valid = 1'b1;
        y        = ya;
        @(posedge clk);
        #1 in_valid = 1'b0;
        guard = 0;
        while (!out_valid && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_first_valid got=%b want=1", out_valid); end
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1;
            y        = yb;
            @(negedge clk);
            total++; if (x !== xa || sat_lo !== la || sat_hi !== ha || out_valid !== 1'b1)
                begin bad++; $display("FAIL bp_hold%0d got=%h/%b/%b/%b want=%h/%b/%b/1", c, x, sat_lo, sat_hi, out_valid, xa, la, ha); end
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready%0d got=%b want=0", c, in_ready); end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_idle got=%b want=1", in_ready); end
        // in_valid still high with yb: this edge is the second handshake.
        @(posedge clk);
        #1 in_valid = 1'b0;
        inv_ref(int'(yb), xb, lb, hb, elat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 60);
        xo = x;
        total++; if (lat !== elat) begin bad++; $display("FAIL bp_second_latency got=%0d want=%0d", lat, elat); end
        total++; if (xo !== xb || sat_lo !== lb || sat_hi !== hb)
            begin bad++; $display("FAIL bp_second_result got=%h/%b/%b want=%h/%b/%b", xo, sat_lo, sat_hi, xb, lb, hb); end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_search();
        logic [15:0] xe, xo;
        logic        elo, ehi, slo, shi;
        int          lat, elat, seen;
        in_valid = 1'b1;
        y        = 16'd5000;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (7) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || x !== 16'h0000 || sat_lo !== 1'b0 || sat_hi !== 1'b0)
            begin bad++; $display("FAIL rst_mid_outputs got=%b/%b/%h/%b/%b want=0/1/0000/0/0", out_valid, in_ready, x, sat_lo, sat_hi); end
        repeat (3) @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL rst_mid_no_pulse got=%0d want=0", seen); end
        do_txn(16'd5000, 1, lat, xo, slo, shi);
        inv_ref(5000, xe, elo, ehi, elat);
        total++; if (lat !== elat) begin bad++; $display("FAIL rst_mid_latency got=%0d want=%0d", lat, elat); end
        total++; if (xo !== xe || slo !== elo || shi !== ehi)
            begin bad++; $display("FAIL rst_mid_result got=%h/%b/%b want=%h/%b/%b", xo, slo, shi, xe, elo, ehi); end
    endtask

    task automatic test_random_sweep();
        logic [15:0] yv, xe, xo;
        logic        elo, ehi, slo, shi;
        int          lat, elat;
        for (int i = 0; i < NUM_RAND; i++) begin
            if ($urandom_range(0, 3) == 0) yv = 16'($urandom);
            else                           yv = 16'($urandom_range(0, 16000));
            do_txn(yv, int'($urandom_range(0, 2)), lat, xo, slo, shi);
            inv_ref(int'(yv), xe, elo, ehi, elat);
            total++; if (lat !== elat) begin bad++; $display("FAIL rand%0d_latency y=%h got=%0d want=%0d", i, yv, lat, elat); end
            total++; if (xo !== xe) begin bad++; $display("FAIL rand%0d_x y=%h got=%h want=%h", i, yv, xo, xe); end
            total++; if (slo !== elo || shi !== ehi)
                begin bad++; $display("FAIL rand%0d_flags y=%h got=%b/%b want=%b/%b", i, yv, slo, shi, elo, ehi); end
        end
    endtask

    initial begin
        for (int k = -2048; k <= 2048; k++) f_tab[k + 2048] = f_ref(k);
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_search();
        test_random_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
